// File: rtl/process_node_seq.sv
// Registered, time-multiplexed node relaxation: one request is relaxed NUM_PE
// neighbours per cycle over NUM_VIZINHOS/NUM_PE cycles, then done_out pulses.
module process_node_seq #(
  parameter int unsigned DIST_WIDTH   = 8,
  parameter int unsigned CUSTO_WIDTH  = 8,
  parameter int unsigned NUM_VIZINHOS = 8,
  parameter int unsigned NUM_PE       = 2
) (
  input  logic                                 clk,
  input  logic                                 rst,
  input  logic                                 start_in,
  output logic                                 ready_out,
  input  logic [DIST_WIDTH-1:0]                dist_no_in,
  input  logic [CUSTO_WIDTH*NUM_VIZINHOS-1:0]  custo_vizinhos_in,
  input  logic [DIST_WIDTH*NUM_VIZINHOS-1:0]   dist_vizinhos_in,
  input  logic [NUM_VIZINHOS-1:0]              vizinho_valido_in,
  output logic                                 done_out,
  output logic [NUM_VIZINHOS-1:0]              update_out,
  output logic [DIST_WIDTH*NUM_VIZINHOS-1:0]   nova_dist_out
);

  localparam int unsigned G  = NUM_VIZINHOS / NUM_PE;
  localparam int unsigned GW = (G > 1) ? $clog2(G) : 1;
  localparam logic [DIST_WIDTH-1:0] DIST_INF = '1;

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

  state_t                              r_state, w_state_nxt;
  logic [GW-1:0]                       r_grp;
  logic [DIST_WIDTH-1:0]               r_dist_no;
  logic [CUSTO_WIDTH*NUM_VIZINHOS-1:0] r_custo;
  logic [DIST_WIDTH*NUM_VIZINHOS-1:0]  r_dist_viz;
  logic [DIST_WIDTH*NUM_VIZINHOS-1:0]  r_nova;
  logic [NUM_VIZINHOS-1:0]             r_valido;
  logic [NUM_VIZINHOS-1:0]             r_upd;
  logic                                r_done;

  logic                                w_accept;
  logic                                w_last;
  logic [CUSTO_WIDTH-1:0]              w_custo;
  logic [DIST_WIDTH-1:0]               w_viz;
  logic [DIST_WIDTH:0]                 w_soma;
  logic [DIST_WIDTH-1:0]               w_sat;
  int unsigned                         w_idx  [NUM_PE];
  logic [DIST_WIDTH-1:0]               w_nova [NUM_PE];
  logic [NUM_PE-1:0]                   w_upd;

  assign ready_out = (r_state != BUSY);
  assign w_accept  = start_in && ready_out;
  assign w_last    = (r_grp == GW'(G - 1));

  always_ff @(posedge clk) begin
    if (rst) r_state <= IDLE;
    else     r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      IDLE:    if (w_accept) w_state_nxt = BUSY;
      BUSY:    if (w_last)   w_state_nxt = DONE;
      DONE:    w_state_nxt = w_accept ? BUSY : IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

  // Lane k handles neighbour g*NUM_PE+k; the sum is one bit wider so overflow saturates.
  always_comb begin
    w_custo = '0;
    w_viz   = '0;
    w_soma  = '0;
    w_sat   = '0;
    w_upd   = '0;
    for (int unsigned k = 0; k < NUM_PE; k++) begin
      w_idx[k]  = r_grp * NUM_PE + k;
      w_custo   = r_custo[w_idx[k]*CUSTO_WIDTH +: CUSTO_WIDTH];
      w_viz     = r_dist_viz[w_idx[k]*DIST_WIDTH +: DIST_WIDTH];
      w_soma    = {1'b0, r_dist_no} + {{(DIST_WIDTH+1-CUSTO_WIDTH){1'b0}}, w_custo};
      w_sat     = ((w_soma >= {1'b0, DIST_INF}) || (r_dist_no == DIST_INF))
                  ? DIST_INF : w_soma[DIST_WIDTH-1:0];
      w_upd[k]  = r_valido[w_idx[k]] && (w_sat < w_viz);
      w_nova[k] = w_upd[k] ? w_sat : w_viz;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_grp      <= '0;
      r_dist_no  <= '0;
      r_custo    <= '0;
      r_dist_viz <= '0;
      r_valido   <= '0;
      r_nova     <= '0;
      r_upd      <= '0;
      r_done     <= 1'b0;
    end else begin
      r_done <= (r_state == BUSY) && w_last;
      if (w_accept) begin
        r_grp      <= '0;
        r_dist_no  <= dist_no_in;
        r_custo    <= custo_vizinhos_in;
        r_dist_viz <= dist_vizinhos_in;
        r_valido   <= vizinho_valido_in;
        r_nova     <= '0;
        r_upd      <= '0;
      end else if (r_state == BUSY) begin
        r_grp <= r_grp + 1'b1;
        for (int unsigned k = 0; k < NUM_PE; k++) begin
          r_nova[w_idx[k]*DIST_WIDTH +: DIST_WIDTH] <= w_nova[k];
          r_upd[w_idx[k]]                           <= w_upd[k];
        end
      end
    end
  end

  assign done_out      = r_done;
  assign update_out    = r_upd;
  assign nova_dist_out = r_nova;

endmodule

// File: doc/process_node_seq.md
# process_node_seq

Time-multiplexed, registered successor of the combinational node relaxation stage for the shortest-path engine. It accepts one node's distance plus the cost and current distance of each of its `NUM_VIZINHOS` neighbours through a valid/ready handshake. It relaxes them `NUM_PE` at a time using saturating arithmetic and a per-neighbour validity mask. Results and a one-cycle `done_out` pulse go to the distance memory writer.

## Interface
- `DIST_WIDTH`, 8: distance width; the all-ones value is infinity (`DIST_INF`).
- `CUSTO_WIDTH`, 8: edge cost width; must be ≤ `DIST_WIDTH`.
- `NUM_VIZINHOS`, 8: neighbours per node.
- `NUM_PE`, 2: parallel relaxation lanes.
  - `NUM_VIZINHOS % NUM_PE == 0`.
  - `G = NUM_VIZINHOS/NUM_PE` groups.

Ports:
- `clk` in 1: single clock, rising edge.
- `rst` in 1: synchronous, active-high reset.
- `start_in` in 1: request valid.
- `ready_out` out 1: block can accept a request.
- `dist_no_in` in `DIST_WIDTH`: distance of the node being expanded.
- `custo_vizinhos_in` in `CUSTO_WIDTH*NUM_VIZINHOS`: edge costs; neighbour i occupies slice `[CUSTO_WIDTH*i +: CUSTO_WIDTH]`.
- `dist_vizinhos_in` in `DIST_WIDTH*NUM_VIZINHOS`: current neighbour distances, same packing.
- `vizinho_valido_in` in `NUM_VIZINHOS`: bit i = 1 means neighbour i exists.
- `done_out` out 1: one-cycle pulse, results valid.
- `update_out` out `NUM_VIZINHOS`: bit i = 1 means neighbour i improved.
- `nova_dist_out` out `DIST_WIDTH*NUM_VIZINHOS`: resulting neighbour distances, same packing.

## Operation
- FSM states: IDLE, BUSY, DONE. Reset state is IDLE.
- `ready_out` = 1 in IDLE and in DONE, 0 in BUSY. While `rst` = 1, `start_in` is ignored.
- Accept: `start_in && ready_out` at a rising edge.
  - All inputs are latched into internal registers.
  - `update_out` and `nova_dist_out` are cleared to 0.
  - Group counter g is set to 0; FSM moves to BUSY.
  - Inputs may change freely after acceptance.
- BUSY: each cycle, lanes k = 0..`NUM_PE`-1 process neighbour i = g*`NUM_PE`+k from the latched copy.
  - `soma` = `dist_no` + zero-extended `custo_i`, computed `DIST_WIDTH`+1 bits wide.
  - `soma_sat` = `DIST_INF` if `soma` ≥ `DIST_INF` or `dist_no` == `DIST_INF`; otherwise `soma`[`DIST_WIDTH`-1:0].
  - `upd_i` = `valido_i` && (`soma_sat` < `dist_viz_i`), strict compare: a tie gives no update.
  - `nova_i` = `upd_i` ? `soma_sat` : `dist_viz_i`. Masked neighbours pass `dist_viz_i` through with `upd_i` = 0.
  - Group i results are written into the output registers at the end of the cycle; g increments.
  - After group g = G-1, FSM moves to DONE.
- DONE: `done_out` = 1 for exactly this cycle.
  - Without a new `start_in`, FSM moves to IDLE.
  - With `start_in`, the new request is accepted (back-to-back) and FSM goes straight to BUSY.
- Outputs hold their values from `done_out` until the next acceptance.
- Between acceptance and `done_out`, output values are partial and must not be consumed.

## Timing
- Reset values: `done_out` = 0, `update_out` = 0, `nova_dist_out` = 0, `ready_out` = 1 (state IDLE), g = 0.
- Reset in any state, including mid-BUSY: next cycle is IDLE with all outputs at reset values; no `done_out` is emitted for the aborted request.
- Request accepted at edge T: BUSY for cycles T+1..T+G, `done_out` high in cycle T+G+1.
  - Latency = G+1 cycles.
  - Throughput with back-to-back requests = one request per G+1 cycles.
- All outputs are registered; no combinational path from inputs to outputs except `ready_out`, which depends on state only.
- `start_in` during BUSY is ignored; it is not queued.

## Test plan
1. Defaults (8 neighbours, 2 PEs, G = 4), `dist_no` = 10, costs 1..8, all `dist_viz` = 15, mask FF, start at T → `done_out` at T+5. `nova` = 11,12,13,14,15,15,15,15; `update_out` = 0x0F (ties at 15 do not update).
2. `dist_no` = 250, cost = 10 for all, `dist_viz` = FF, mask FF → sums saturate to 255, `update_out` = 0x00, `nova` all 255. With `dist_no` = FF, costs 0 → no updates.
3. Mask = 0x5A, `dist_no` = 0, costs 1, `dist_viz` = 100 → `update_out` = 0x5A; masked lanes keep 100, valid lanes get 1.
4. Request accepted in the DONE cycle of a previous request → second `done_out` exactly 5 cycles later, no idle gap. `start_in` pulsed during BUSY → no effect.
5. `rst` asserted at cycle T+2 of a request → `ready_out` = 1, outputs 0, no `done_out` pulse. A fresh request then completes normally with latency 5.
6. Parameter sweep (`NUM_PE` = 1, 4, 8; `DIST_WIDTH` = 16, `CUSTO_WIDTH` = 8) with random vectors vs. a reference model → latency = `NUM_VIZINHOS`/`NUM_PE`+1, and all results match.
